xor_burst_arbiter: RTL

//   Shares one XOR accumulate datapath between NREQ requesters. Each requester

---
 rtl/xor_burst_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/xor_burst_arbiter.sv
// xor_burst_arbiter: round-robin grant of one requester burst at a time,
// returning the XOR of all burst words tagged with the owner index.
module xor_burst_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id
);
    typedef enum logic [1:0] {IDLE, BURST, RESULT} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d, rr_q, rr_d, res_id_q, res_id_d;
    logic [WIDTH-1:0]  acc_q, acc_d, res_data_q, res_data_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [IDW:0]      sum;
    logic [IDW-1:0]    idx, pick;
    logic [WIDTH-1:0]  word;
    logic              beat;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        acc_d       = acc_q;
        req_ready_d = req_ready_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        sum         = '0;
        idx         = '0;
        pick        = rr_q;
        // walk downwards so the closest valid index at or after rr wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + (IDW+1)'(k);
            idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
            if (req_valid[idx]) pick = idx;
        end
        word = req_data[int'(grant_q)*WIDTH +: WIDTH];
        beat = (state_q == BURST) && req_valid[grant_q] && req_ready_q[grant_q];
        case (state_q)
            IDLE: if (|req_valid) begin
                grant_d     = pick;
                acc_d       = '0;
                req_ready_d = NREQ'(1) << pick;
                state_d     = BURST;
            end
            BURST: if (beat) begin
                acc_d = acc_q ^ word;
                if (req_last[grant_q]) begin
                    res_data_d  = acc_q ^ word;
                    res_id_d    = grant_q;
                    res_valid_d = 1'b1;
                    req_ready_d = '0;
                    state_d     = RESULT;
                end
            end
            RESULT: if (res_ready) begin
                res_valid_d = 1'b0;
                rr_d        = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + IDW'(1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            acc_q       <= '0;
            req_ready_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            acc_q       <= acc_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
endmodule
